pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Parametrised program-counter and fetch-request unit for the pipelined MIPS core, sitting between the branch/jump/exception control logic and the instruction memory port (addra/ena). It holds the fetch address and advances it by a configurable step. It applies redirects with fixed priority and holds the address while the pipeline stalls or memory is busy. A redirect that arrives during a memory wait is buffered, so it is never lost.

## Interface
Parameters:
- ADDR_W, 32, width of PC and all target buses
- RESET_VEC, 32'h0000_0000, first fetch address after reset
- EXC_VEC, 32'hBFC0_0380, exception entry address
- STEP, 4, sequential increment in bytes (power of two)

Ports:
- clk  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- stall  in  1  pipeline stall from hazard unit; hold PC
- exc  in  1  exception request; target EXC_VEC
- jump  in  1  jump request
- jump_target  in  ADDR_W  jump destination
- branch  in  1  branch-taken request
- branch_target  in  ADDR_W  branch destination
- imem_ready  in  1  instruction memory accepted current request
- pc  out  ADDR_W  current fetch address (drives addra)
- inst_ce  out  1  fetch enable (drives ena)
- pc_next_seq  out  ADDR_W  pc + STEP, combinational
- adel  out  1  one-cycle pulse: redirect target misaligned

## Operation
- States: BOOT, RUN, WAIT.
- BOOT: entered on reset.
  - pc=RESET_VEC, inst_ce=0.
  - Goes to RUN on the next clk edge, with pc=RESET_VEC and inst_ce=1.
- RUN: inst_ce=1.
  - On each edge, with imem_ready=1 and stall=0, pc takes the selected next value.
  - With imem_ready=0, move to WAIT and hold pc.
- WAIT: inst_ce=1, pc held.
  - Return to RUN on the edge where imem_ready=1.
  - On that edge pc takes the pending redirect if one exists, else pc+STEP (if stall=0).
- Next-value priority: exc > jump > branch > sequential (pc+STEP).
- stall=1 holds pc unless exc=1, which overrides stall.
- Pending-redirect buffer (one entry, target + valid):
  - Captures any redirect raised in WAIT, or raised while stall=1 in RUN.
  - A higher-priority later request overwrites it; a lower-priority one does not.
  - Cleared when applied.
- Misaligned target (target[log2(STEP)-1:0] != 0 on jump/branch):
  - The target is not loaded; pc loads EXC_VEC instead.
  - adel pulses for one cycle, coincident with that load.
- Arithmetic: pc+STEP is modulo 2^ADDR_W; wrap from all-ones-minus-STEP+1 to 0 is silent.

## Timing
- Reset values: pc=RESET_VEC, inst_ce=0, adel=0, pending valid=0, state=BOOT.
- RST is asynchronous. Asserting it mid-WAIT or with a pending redirect discards everything and returns to BOOT.
- Redirect latency: one cycle. A request sampled at edge N makes pc=target after edge N, provided imem_ready=1 and the request is not stalled.
- Buffered redirect: applied on the first edge where imem_ready=1 and (stall=0 or exc pending).
- Simultaneous requests:
  - exc+jump+branch in the same cycle: exc wins; the others are dropped, not buffered.
  - A jump that arrives with a buffered exc is dropped.
- pc_next_seq is combinational from pc; it has no register latency.

## Structure
- Shared package `cpu_pkg`:
  - fetch-state enum (BOOT/RUN/WAIT)
  - redirect-source encoding (NONE/BR/JMP/EXC, ordered by priority)
  - default RESET_VEC and EXC_VEC constants
- One sub-module: `redirect_buf`, holding the single-entry priority-overwrite buffer (target, source, valid, clear).
- Sequential-increment adder stays inline.

## Test plan
- Reset then run, imem_ready=1:
  - cycle 0: inst_ce=0, pc=0
  - cycle 1: inst_ce=1, pc=0
  - then pc=4, 8, 12
- Branch at pc=0x10 to 0x40 in the same cycle as jump to 0x80 → pc=0x80 next cycle; the branch is dropped.
- imem_ready=0 for 3 cycles while branch to 0x200 is pulsed in the first waiting cycle:
  - pc holds
  - pc=0x200 on the edge where imem_ready returns
- stall=1 with exc=1 at pc=0x24 → pc=0xBFC00380 next cycle despite the stall.
- Jump to 0x102 → pc=0xBFC00380 and adel=1 for exactly one cycle.
- RST asserted asynchronously mid-WAIT with a pending redirect → pc=RESET_VEC and inst_ce=0 immediately; the buffered target is never fetched. With STEP=4, pc=0xFFFFFFFC advances to 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end of the pipelined MIPS core.
package cpu_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StWait
  } fetch_state_e;

  // Encoded in ascending priority so a plain magnitude compare picks the winner.
  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcBr   = 2'd1,
    SrcJmp  = 2'd2,
    SrcExc  = 2'd3
  } redir_src_e;

  localparam logic [31:0] ResetVecDefault = 32'h0000_0000;
  localparam logic [31:0] ExcVecDefault   = 32'hBFC0_0380;

  function automatic redir_src_e pick_src(input logic exc, input logic jump, input logic branch);
    if (exc) begin
      return SrcExc;
    end else if (jump) begin
      return SrcJmp;
    end else if (branch) begin
      return SrcBr;
    end
    return SrcNone;
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control-side requests and instruction-memory fetch signals of the PC unit.
interface pc_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              stall;
  logic              exc;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              branch;
  logic [ADDR_W-1:0] branch_target;
  logic              imem_ready;
  logic [ADDR_W-1:0] pc;
  logic              inst_ce;
  logic [ADDR_W-1:0] pc_next_seq;
  logic              adel;

  modport master (
    output stall, exc, jump, jump_target, branch, branch_target, imem_ready,
    input  pc, inst_ce, pc_next_seq, adel
  );

  modport slave (
    input  stall, exc, jump, jump_target, branch, branch_target, imem_ready,
    output pc, inst_ce, pc_next_seq, adel
  );
endinterface

// File: rtl/redirect_buf.sv
// Single-entry redirect buffer; a stored request is replaced only by an equal or higher priority one.
module redirect_buf
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              RST,
  input  redir_src_e        live_src,
  input  logic [ADDR_W-1:0] live_target,
  input  logic              capture,
  input  logic              clear,
  output redir_src_e        sel_src,
  output logic [ADDR_W-1:0] sel_target
);

  logic              valid_q;
  redir_src_e        src_q;
  logic [ADDR_W-1:0] target_q;
  redir_src_e        held_src;

  // sel_* is the winner of the stored entry and this cycle's request.
  always_comb begin
    held_src = valid_q ? src_q : SrcNone;
    if (live_src != SrcNone && live_src >= held_src) begin
      sel_src    = live_src;
      sel_target = live_target;
    end else begin
      sel_src    = held_src;
      sel_target = target_q;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      valid_q  <= 1'b0;
      src_q    <= SrcNone;
      target_q <= '0;
    end else if (clear) begin
      valid_q <= 1'b0;
    end else if (capture && sel_src != SrcNone) begin
      valid_q  <= 1'b1;
      src_q    <= sel_src;
      target_q <= sel_target;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request unit: sequential advance, prioritised redirects,
// stall/memory-wait hold and misaligned-target trapping.
module pc_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(ResetVecDefault),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(ExcVecDefault),
  parameter int unsigned       STEP      = 4
) (
  input logic            clk,
  input logic            RST,
  pc_fetch_unit_if.slave fif
);

  localparam logic [ADDR_W-1:0] StepVal   = ADDR_W'(STEP);
  localparam logic [ADDR_W-1:0] AlignMask = ADDR_W'(STEP - 1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              inst_ce_q;
  logic              adel_q;

  redir_src_e        live_src;
  logic [ADDR_W-1:0] live_target;
  redir_src_e        sel_src;
  logic [ADDR_W-1:0] sel_target;
  logic [ADDR_W-1:0] pc_seq;
  logic              active;
  logic              apply;
  logic              advance;
  logic              misaligned;

  always_comb begin
    live_src = pick_src(fif.exc, fif.jump, fif.branch);
    unique case (live_src)
      SrcExc:  live_target = EXC_VEC;
      SrcJmp:  live_target = fif.jump_target;
      SrcBr:   live_target = fif.branch_target;
      default: live_target = '0;
    endcase
  end

  assign pc_seq     = pc_q + StepVal;
  assign active     = (state_q != StBoot);
  // An exception is the only redirect allowed to break through a stall.
  assign apply      = active && fif.imem_ready && (sel_src != SrcNone) &&
                      (!fif.stall || sel_src == SrcExc);
  assign advance    = active && fif.imem_ready && !fif.stall && (sel_src == SrcNone);
  assign misaligned = (sel_src == SrcJmp || sel_src == SrcBr) && |(sel_target & AlignMask);

  redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk         (clk),
    .RST         (RST),
    .live_src    (live_src),
    .live_target (live_target),
    .capture     (active && !apply),
    .clear       (apply),
    .sel_src     (sel_src),
    .sel_target  (sel_target)
  );

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= StBoot;
      pc_q      <= RESET_VEC;
      inst_ce_q <= 1'b0;
      adel_q    <= 1'b0;
    end else begin
      adel_q <= 1'b0;
      unique case (state_q)
        StBoot: begin
          state_q   <= StRun;
          inst_ce_q <= 1'b1;
        end
        StRun, StWait: begin
          state_q <= fif.imem_ready ? StRun : StWait;
          if (apply) begin
            pc_q   <= misaligned ? EXC_VEC : sel_target;
            adel_q <= misaligned;
          end else if (advance) begin
            pc_q <= pc_seq;
          end
        end
        default: begin
          state_q   <= StBoot;
          inst_ce_q <= 1'b0;
        end
      endcase
    end
  end

  assign fif.pc          = pc_q;
  assign fif.inst_ce     = inst_ce_q;
  assign fif.pc_next_seq = pc_seq;
  assign fif.adel        = adel_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios then random traffic against a reference model.
module tb_pc_fetch_unit;

  localparam int unsigned AW   = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] EV   = 32'hBFC0_0380;
  localparam int unsigned STEP = 4;

  logic clk = 1'b0;
  logic RST = 1'b1;
  always #5 clk = ~clk;

  pc_fetch_unit_if #(.ADDR_W(AW)) fif ();

  pc_fetch_unit #(
    .ADDR_W    (AW),
    .RESET_VEC (RV),
    .EXC_VEC   (EV),
    .STEP      (STEP)
  ) dut (
    .clk (clk),
    .RST (RST),
    .fif (fif)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ce;
    logic        adel;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: fetch address, boot flag and one pending redirect (priority 0 = none).
  logic [31:0] m_pc = RV;
  logic        m_ce = 1'b0;
  logic        m_adel = 1'b0;
  logic        m_booted = 1'b0;
  int          m_pend_pri = 0;
  logic [31:0] m_pend_tgt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic stall, input logic exc, input logic jump,
                            input logic [31:0] jt, input logic branch, input logic [31:0] bt,
                            input logic ready);
    int          live_pri;
    logic [31:0] live_tgt;
    int          win_pri;
    logic [31:0] win_tgt;
    if (rst) begin
      m_pc = RV; m_ce = 1'b0; m_adel = 1'b0; m_booted = 1'b0; m_pend_pri = 0;
      return;
    end
    m_adel = 1'b0;
    if (!m_booted) begin
      m_booted = 1'b1;
      m_ce = 1'b1;
      return;
    end
    live_pri = exc ? 3 : jump ? 2 : branch ? 1 : 0;
    live_tgt = exc ? EV : jump ? jt : bt;
    if (live_pri != 0 && live_pri >= m_pend_pri) begin
      win_pri = live_pri; win_tgt = live_tgt;
    end else begin
      win_pri = m_pend_pri; win_tgt = m_pend_tgt;
    end
    if (ready && win_pri != 0 && (!stall || win_pri == 3)) begin
      if (win_pri != 3 && (win_tgt % STEP) != 0) begin
        m_pc = EV;
        m_adel = 1'b1;
      end else begin
        m_pc = win_tgt;
      end
      m_pend_pri = 0;
    end else begin
      m_pend_pri = win_pri;
      m_pend_tgt = win_tgt;
      if (ready && !stall) m_pc = m_pc + STEP;
    end
  endtask

  // Inputs change 2 units after the falling edge, after the monitor has sampled.
  task automatic drive(input logic rst, input logic stall, input logic exc, input logic jump,
                       input logic [31:0] jt, input logic branch, input logic [31:0] bt,
                       input logic ready);
    exp_t e;
    @(negedge clk);
    #2;
    fif.stall = stall; fif.exc = exc; fif.jump = jump; fif.jump_target = jt;
    fif.branch = branch; fif.branch_target = bt; fif.imem_ready = ready;
    if (rst && !RST) begin
      RST = 1'b1;
      #1;
      check("async_rst_pc", fif.pc, RV);
      check("async_rst_ce", 32'(fif.inst_ce), 32'd0);
      check("async_rst_adel", 32'(fif.adel), 32'd0);
    end
    RST = rst;
    model_step(rst, stall, exc, jump, jt, branch, bt, ready);
    e.pc = m_pc; e.ce = m_ce; e.adel = m_adel;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("pc", fif.pc, e.pc);
        check("inst_ce", 32'(fif.inst_ce), 32'(e.ce));
        check("adel", 32'(fif.adel), 32'(e.adel));
        check("pc_next_seq", fif.pc_next_seq, e.pc + STEP);
      end
    end
  end

  initial begin : stimulus
    logic [31:0] jt;
    logic [31:0] bt;
    fif.stall = 1'b0; fif.exc = 1'b0; fif.jump = 1'b0; fif.jump_target = '0;
    fif.branch = 1'b0; fif.branch_target = '0; fif.imem_ready = 1'b1;

    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(5);                                                   // boot, then 0 -> 4 -> 8 -> 0xC -> 0x10
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h40, 1'b1); // jump beats branch
    idle(1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h200, 1'b0);    // branch during memory wait
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);         // buffered 0x200 applied
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h24, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0, '0, 1'b1);         // exc through stall
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h102, 1'b0, '0, 1'b1);    // misaligned jump
    idle(2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, 32'h300, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);         // async reset mid-wait
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(3);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h60, 1'b0, '0, 1'b1);     // stalled jump buffered
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1, 32'h70, 1'b1);     // lower-priority branch ignored
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 1'b1);
    idle(2);                                                   // wraps to 0, then 4

    for (int i = 0; i < 600; i++) begin
      jt = $urandom;
      bt = $urandom;
      if ($urandom_range(0, 7) != 0) jt[1:0] = 2'b00;
      if ($urandom_range(0, 7) != 0) bt[1:0] = 2'b00;
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 5) == 0, jt, $urandom_range(0, 4) == 0, bt,
            $urandom_range(0, 3) != 0);
    end

    idle(2);
    @(negedge clk);
    #3;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
